// File: rtl/wb_select_stage_if.sv
// Bus bundle for the MEM/WB write-back selector: stage inputs from MEM and
// registered register-file write port toward the register file.
interface wb_select_stage_if #(
    parameter int BITS_SIZE = 32,
    parameter int NUM_SRC   = 4,
    parameter int REG_ADDR  = 5
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic                         i_valid;
    logic                         i_stall;
    logic                         i_flush;
    logic [SEL_W-1:0]             i_wb_sel;
    logic [NUM_SRC*BITS_SIZE-1:0] i_src_data;
    logic [1:0]                   i_load_width;
    logic                         i_load_unsigned;
    logic [1:0]                   i_byte_off;
    logic                         i_reg_write;
    logic [REG_ADDR-1:0]          i_rd;
    logic [BITS_SIZE-1:0]         o_write_data;
    logic [REG_ADDR-1:0]          o_rd;
    logic                         o_reg_write;
    logic                         o_valid;
    logic [31:0]                  o_retired_count;

    modport master (
        output i_valid, i_stall, i_flush, i_wb_sel, i_src_data, i_load_width,
               i_load_unsigned, i_byte_off, i_reg_write, i_rd,
        input  o_write_data, o_rd, o_reg_write, o_valid, o_retired_count
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_wb_sel, i_src_data, i_load_width,
               i_load_unsigned, i_byte_off, i_reg_write, i_rd,
        output o_write_data, o_rd, o_reg_write, o_valid, o_retired_count
    );
endinterface

// File: rtl/wb_select_stage.sv
// Registered N-source write-back selector with r0 suppression, stall/flush and
// a retired-instruction counter. Define WB_LOAD_ALIGN_EN to build byte/half load extraction.
module wb_select_stage #(
    parameter int BITS_SIZE = 32,
    parameter int NUM_SRC   = 4,
    parameter int REG_ADDR  = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    wb_select_stage_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_SRC);

    logic [BITS_SIZE-1:0] sel_data_s;
    logic [BITS_SIZE-1:0] wb_data_s;
    logic                 cap_s;
    logic [BITS_SIZE-1:0] write_data_r;
    logic [REG_ADDR-1:0]  rd_r;
    logic                 reg_write_r;
    logic                 valid_r;
    logic [31:0]          retired_cnt_r;

    assign cap_s = !bus.i_stall && !bus.i_flush;

    // Source mux; an index past the last source yields zero
    always_comb begin
        sel_data_s = {BITS_SIZE{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            sel_data_s = (int'(bus.i_wb_sel) == k) ? bus.i_src_data[k*BITS_SIZE +: BITS_SIZE]
                                                   : sel_data_s;
        end
    end

`ifdef WB_LOAD_ALIGN_EN
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        sign_s;

    // Little-endian lane extraction and extension, only for the memory source
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        sign_s    = 1'b0;
        wb_data_s = sel_data_s;
        case (bus.i_byte_off)
            2'd0:    byte_s = sel_data_s[7:0];
            2'd1:    byte_s = sel_data_s[15:8];
            2'd2:    byte_s = sel_data_s[23:16];
            2'd3:    byte_s = sel_data_s[31:24];
            default: byte_s = sel_data_s[7:0];
        endcase
        if (bus.i_byte_off[1]) begin
            half_s = sel_data_s[31:16];
        end else begin
            half_s = sel_data_s[15:0];
        end
        if (bus.i_wb_sel == SEL_W'(1)) begin
            case (bus.i_load_width)
                2'b00: begin
                    sign_s    = !bus.i_load_unsigned && byte_s[7];
                    wb_data_s = {{24{sign_s}}, byte_s};
                end
                2'b01: begin
                    sign_s    = !bus.i_load_unsigned && half_s[15];
                    wb_data_s = {{16{sign_s}}, half_s};
                end
                default: wb_data_s = sel_data_s;
            endcase
        end else begin
            wb_data_s = sel_data_s;
        end
    end
`else
    logic unused_load_s;

    assign unused_load_s = ^{bus.i_load_width, bus.i_load_unsigned, bus.i_byte_off};
    assign wb_data_s     = sel_data_s;
`endif

    // Pipeline register: flush kills the capture even under stall, data/rd hold
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            write_data_r  <= {BITS_SIZE{1'b0}};
            rd_r          <= {REG_ADDR{1'b0}};
            reg_write_r   <= 1'b0;
            valid_r       <= 1'b0;
            retired_cnt_r <= 32'h0000_0000;
        end else if (bus.i_flush) begin
            reg_write_r <= 1'b0;
            valid_r     <= 1'b0;
        end else if (cap_s) begin
            write_data_r <= wb_data_s;
            rd_r         <= bus.i_rd;
            reg_write_r  <= bus.i_reg_write && bus.i_valid && (bus.i_rd != {REG_ADDR{1'b0}});
            valid_r      <= bus.i_valid;
            if (bus.i_valid) begin
                retired_cnt_r <= retired_cnt_r + 32'd1;
            end
        end
    end

    assign bus.o_write_data    = write_data_r;
    assign bus.o_rd            = rd_r;
    assign bus.o_reg_write     = reg_write_r;
    assign bus.o_valid         = valid_r;
    assign bus.o_retired_count = retired_cnt_r;
endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage built with three sources so that select
// value 3 is out of range; load expectations follow WB_LOAD_ALIGN_EN.
module tb_wb_select_stage;
    logic i_clk;
    logic i_reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] exp_cnt;

    wb_select_stage_if #(.BITS_SIZE(32), .NUM_SRC(3), .REG_ADDR(5)) bus ();

    wb_select_stage #(.BITS_SIZE(32), .NUM_SRC(3), .REG_ADDR(5)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_in(input logic valid, input logic [1:0] sel, input logic [31:0] s0,
                          input logic [31:0] s1, input logic [31:0] s2, input logic [1:0] width,
                          input logic uns, input logic [1:0] off, input logic regw,
                          input logic [4:0] rd);
        bus.i_valid         = valid;
        bus.i_wb_sel        = sel;
        bus.i_src_data      = {s2, s1, s0};
        bus.i_load_width    = width;
        bus.i_load_unsigned = uns;
        bus.i_byte_off      = off;
        bus.i_reg_write     = regw;
        bus.i_rd            = rd;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        set_in(1'b1, 2'd0, 32'hAAAA_0001, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 5'd7);
        tick();
        tick();
        bus.i_stall = 1'b1;
        bus.i_flush = 1'b1;
        #2;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid} !== 39'h0) begin
            n_fail++;
            $display("FAIL reset_async: got data=%h rd=%0d we=%b v=%b, required all 0",
                     bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid);
        end
        n_checks++;
        if (bus.o_retired_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d required 0", bus.o_retired_count);
        end
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        tick();
        n_checks++;
        if ({bus.o_write_data, bus.o_valid, bus.o_retired_count} !== 65'h0) begin
            n_fail++;
            $display("FAIL reset_held: got data=%h v=%b cnt=%0d, required 0",
                     bus.o_write_data, bus.o_valid, bus.o_retired_count);
        end
        i_reset = 1'b1;
        exp_cnt = 32'd0;
        set_in(1'b1, 2'd0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0, 2'b00, 1'b0, 2'd3, 1'b1, 5'd5);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if ({bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid} !== {32'h1234_5678, 5'd5, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL alu_select: got data=%h rd=%0d we=%b v=%b, required 12345678/5/1/1",
                     bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid);
        end
        n_checks++;
        if (bus.o_retired_count !== 32'd1) begin
            n_fail++;
            $display("FAIL count_first: got %0d required 1", bus.o_retired_count);
        end
    endtask

    task automatic test_load_align();
        logic [31:0] exp_v [4];
        logic [1:0]  wid   [4];
        logic        uns   [4];
        logic [1:0]  off   [4];
        logic [31:0] src   [4];
`ifdef WB_LOAD_ALIGN_EN
        exp_v = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_8001, 32'h0000_7FFE};
`else
        exp_v = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h8001_7FFE, 32'h8001_7FFE};
`endif
        wid = '{2'b00, 2'b00, 2'b01, 2'b01};
        uns = '{1'b0, 1'b1, 1'b0, 1'b0};
        off = '{2'd3, 2'd2, 2'd2, 2'd0};
        src = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h8001_7FFE, 32'h8001_7FFE};
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'd1, 32'h0, src[i], 32'h0, wid[i], uns[i], off[i], 1'b1, 5'd9);
            tick();
            exp_cnt = exp_cnt + 32'd1;
            n_checks++;
            if (bus.o_write_data !== exp_v[i]) begin
                n_fail++;
                $display("FAIL load_%0d: got %h required %h", i, bus.o_write_data, exp_v[i]);
            end
        end
        set_in(1'b1, 2'd0, 32'h0000_0080, 32'h0, 32'h0, 2'b00, 1'b0, 2'd0, 1'b1, 5'd9);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if (bus.o_write_data !== 32'h0000_0080) begin
            n_fail++;
            $display("FAIL alu_no_extend: got %h required 00000080", bus.o_write_data);
        end
        set_in(1'b1, 2'd1, 32'h0, 32'hCAFE_F00D, 32'h0, 2'b10, 1'b0, 2'd1, 1'b1, 5'd9);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if (bus.o_write_data !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL load_word: got %h required cafef00d", bus.o_write_data);
        end
    endtask

    task automatic test_r0_and_range();
        set_in(1'b1, 2'd2, 32'h1, 32'h2, 32'h5555_AAAA, 2'b10, 1'b0, 2'd0, 1'b1, 5'd0);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if ({bus.o_reg_write, bus.o_valid, bus.o_write_data} !== {1'b0, 1'b1, 32'h5555_AAAA}) begin
            n_fail++;
            $display("FAIL r0_suppress: got we=%b v=%b data=%h required 0/1/5555aaaa",
                     bus.o_reg_write, bus.o_valid, bus.o_write_data);
        end
        set_in(1'b1, 2'd3, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 2'b10, 1'b0, 2'd0, 1'b1, 5'd31);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if ({bus.o_write_data, bus.o_rd, bus.o_reg_write} !== {32'h0, 5'd31, 1'b1}) begin
            n_fail++;
            $display("FAIL sel_out_of_range: got data=%h rd=%0d we=%b required 0/31/1",
                     bus.o_write_data, bus.o_rd, bus.o_reg_write);
        end
        set_in(1'b1, 2'd0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b0, 5'd4);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++;
        if ({bus.o_reg_write, bus.o_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL no_reg_write: got we=%b v=%b required 0/1", bus.o_reg_write, bus.o_valid);
        end
    endtask

    task automatic test_stall_flush();
        set_in(1'b1, 2'd0, 32'hABCD_0123, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 5'd12);
        tick();
        exp_cnt = exp_cnt + 32'd1;
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 2'd0, 32'h0F0F_0000 + 32'(i), 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 5'(20 + i));
            tick();
            n_checks++;
            if ({bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid, bus.o_retired_count}
                !== {32'hABCD_0123, 5'd12, 1'b1, 1'b1, exp_cnt}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got data=%h rd=%0d we=%b v=%b cnt=%0d required abcd0123/12/1/1/%0d",
                         i, bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid,
                         bus.o_retired_count, exp_cnt);
            end
        end
        bus.i_flush = 1'b1;
        set_in(1'b1, 2'd0, 32'h7777_7777, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 5'd3);
        tick();
        n_checks++;
        if ({bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid, bus.o_retired_count}
            !== {32'hABCD_0123, 5'd12, 1'b0, 1'b0, exp_cnt}) begin
            n_fail++;
            $display("FAIL stall_flush: got data=%h rd=%0d we=%b v=%b cnt=%0d required abcd0123/12/0/0/%0d",
                     bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid,
                     bus.o_retired_count, exp_cnt);
        end
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        set_in(1'b0, 2'd0, 32'h0BAD_F00D, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 5'd8);
        tick();
        n_checks++;
        if ({bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid, bus.o_retired_count}
            !== {32'h0BAD_F00D, 5'd8, 1'b0, 1'b0, exp_cnt}) begin
            n_fail++;
            $display("FAIL bubble: got data=%h rd=%0d we=%b v=%b cnt=%0d required 0badf00d/8/0/0/%0d",
                     bus.o_write_data, bus.o_rd, bus.o_reg_write, bus.o_valid,
                     bus.o_retired_count, exp_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        set_in(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b0, 5'd0);
        #2;
        force dut.retired_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_cnt_r;
        set_in(1'b1, 2'd0, 32'h0000_0042, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b1, 5'd1);
        tick();
        n_checks++;
        if (bus.o_retired_count !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL count_wrap: got %h required 00000000", bus.o_retired_count);
        end
        tick();
        n_checks++;
        if (bus.o_retired_count !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL count_after_wrap: got %h required 00000001", bus.o_retired_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 32'd0;
        i_reset  = 1'b0;
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;
        set_in(1'b0, 2'd0, 32'h0, 32'h0, 32'h0, 2'b10, 1'b0, 2'd0, 1'b0, 5'd0);
        #12;
        i_reset = 1'b1;
        test_reset();
        test_load_align();
        test_r0_and_range();
        test_stall_flush();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
